rvh_ptw_mem_responder: RTL and testbench

RVH_PTW_MEM_RESPONDER -- requirements
Module: rvh_ptw_mem_responder

---
 rtl/rvh_ptw_mem_responder_if.sv | 32 +++
 rtl/rvh_ptw_mem_responder.sv | 91 +++++++++
 tb/tb_rvh_ptw_mem_responder.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/rvh_ptw_mem_responder_if.sv
// rvh_ptw_mem_responder_if: PTW walk request/response and memory read channels of the responder
interface rvh_ptw_mem_responder_if #(
  parameter int PADDR_WIDTH = 56,
  parameter int PTE_WIDTH   = 64
);
  logic                   ptw_walk_req_vld_i;
  logic                   ptw_walk_req_id_i;
  logic [PADDR_WIDTH-1:0] ptw_walk_req_addr_i;
  logic                   ptw_walk_req_rdy_o;
  logic                   ptw_walk_resp_vld_o;
  logic [PTE_WIDTH-1:0]   ptw_walk_resp_pte_o;
  logic                   ptw_walk_resp_rdy_i;
  logic                   mem_req_vld_o;
  logic [PADDR_WIDTH-1:0] mem_req_addr_o;
  logic                   mem_req_rdy_i;
  logic                   mem_resp_vld_i;
  logic [PTE_WIDTH-1:0]   mem_resp_data_i;
  logic                   mem_resp_err_i;
  logic                   mem_resp_rdy_o;
  modport slave (
    input  ptw_walk_req_vld_i, ptw_walk_req_id_i, ptw_walk_req_addr_i, ptw_walk_resp_rdy_i,
    input  mem_req_rdy_i, mem_resp_vld_i, mem_resp_data_i, mem_resp_err_i,
    output ptw_walk_req_rdy_o, ptw_walk_resp_vld_o, ptw_walk_resp_pte_o,
    output mem_req_vld_o, mem_req_addr_o, mem_resp_rdy_o
  );
  modport master (
    output ptw_walk_req_vld_i, ptw_walk_req_id_i, ptw_walk_req_addr_i, ptw_walk_resp_rdy_i,
    output mem_req_rdy_i, mem_resp_vld_i, mem_resp_data_i, mem_resp_err_i,
    input  ptw_walk_req_rdy_o, ptw_walk_resp_vld_o, ptw_walk_resp_pte_o,
    input  mem_req_vld_o, mem_req_addr_o, mem_resp_rdy_o
  );
endinterface

// File: rtl/rvh_ptw_mem_responder.sv
// rvh_ptw_mem_responder: single-outstanding PTE fetch engine; optional memory-wait timeout under RVH_PTW_MEM_TIMEOUT_EN
module rvh_ptw_mem_responder #(
  parameter int PADDR_WIDTH    = 56,
  parameter int PTE_WIDTH      = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  rvh_ptw_mem_responder_if.slave  bus,
  output logic [7:0]              err_cnt_o
);
  typedef enum logic [1:0] {IDLE, MEM_REQ, MEM_WAIT, RESP} state_e;
  state_e                 state_q, state_d;
  logic [PADDR_WIDTH-1:0] addr_q, addr_d;
  logic                   id_q, id_d;
  logic [PTE_WIDTH-1:0]   pte_q, pte_d;
  logic [7:0]             err_cnt_q, err_cnt_d;
  logic                   err_inc;
  logic                   tmo_hit;
  logic                   drop_q;
  logic                   unused_id;
  assign unused_id = id_q;
`ifdef RVH_PTW_MEM_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] tmo_q;
  assign tmo_hit = state_q == MEM_WAIT && !bus.mem_resp_vld_i && tmo_q == TW'(TIMEOUT_CYCLES - 1);
  // wait-cycle counter and the flag that swallows the late read after a timeout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q  <= '0;
      drop_q <= 1'b0;
    end else begin
      tmo_q  <= state_q == MEM_WAIT ? tmo_q + TW'(1) : '0;
      drop_q <= tmo_hit ? 1'b1 : (drop_q && bus.mem_resp_vld_i) ? 1'b0 : drop_q;
    end
  end
`else
  logic [31:0] unused_tmo;
  assign unused_tmo = TIMEOUT_CYCLES;
  assign tmo_hit    = 1'b0;
  assign drop_q     = 1'b0;
`endif
  assign bus.ptw_walk_req_rdy_o  = state_q == IDLE && !drop_q;
  assign bus.ptw_walk_resp_vld_o = state_q == RESP;
  assign bus.ptw_walk_resp_pte_o = pte_q;
  assign bus.mem_req_vld_o       = state_q == MEM_REQ;
  assign bus.mem_req_addr_o      = {addr_q[PADDR_WIDTH-1:3], 3'b000};
  assign bus.mem_resp_rdy_o      = state_q == MEM_WAIT || drop_q;
  assign err_cnt_o               = err_cnt_q;
  // walk sequencing: misaligned requests bypass memory, faults return a zero PTE
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    id_d    = id_q;
    pte_d   = pte_q;
    err_inc = 1'b0;
    case (state_q)
      IDLE: if (bus.ptw_walk_req_vld_i && !drop_q) begin
        addr_d  = bus.ptw_walk_req_addr_i;
        id_d    = bus.ptw_walk_req_id_i;
        err_inc = |bus.ptw_walk_req_addr_i[2:0];
        pte_d   = err_inc ? '0 : pte_q;
        state_d = err_inc ? RESP : MEM_REQ;
      end
      MEM_REQ: state_d = bus.mem_req_rdy_i ? MEM_WAIT : MEM_REQ;
      MEM_WAIT: if (bus.mem_resp_vld_i || tmo_hit) begin
        pte_d   = (bus.mem_resp_vld_i && !bus.mem_resp_err_i) ? bus.mem_resp_data_i : '0;
        err_inc = !bus.mem_resp_vld_i || bus.mem_resp_err_i;
        state_d = RESP;
      end
      default: state_d = bus.ptw_walk_resp_rdy_i ? IDLE : RESP;
    endcase
    err_cnt_d = (err_inc && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
  end
  // walk state, captured request and returned PTE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      id_q      <= 1'b0;
      pte_q     <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      id_q      <= id_d;
      pte_q     <= pte_d;
      err_cnt_q <= err_cnt_d;
    end
  end
endmodule

// File: tb/tb_rvh_ptw_mem_responder.sv
// tb_rvh_ptw_mem_responder: directed bench for the PTW memory responder; timeout scenario built with RVH_PTW_MEM_TIMEOUT_EN
module tb_rvh_ptw_mem_responder;
  logic clk = 1'b0;
  logic rst;
  logic [7:0] err_cnt;
  int pass_cnt = 0;
  int total_cnt = 0;
  always #5 clk = ~clk;
  rvh_ptw_mem_responder_if #(.PADDR_WIDTH(56), .PTE_WIDTH(64)) bus ();
  rvh_ptw_mem_responder #(.PADDR_WIDTH(56), .PTE_WIDTH(64), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .bus(bus), .err_cnt_o(err_cnt)
  );
  task automatic step();
    @(negedge clk);
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    total_cnt++; if (bus.ptw_walk_resp_vld_o !== 1'b0) $display("FAIL rst_resp_vld got=%b exp=0", bus.ptw_walk_resp_vld_o); else pass_cnt++;
    total_cnt++; if (bus.mem_req_vld_o !== 1'b0) $display("FAIL rst_mem_req_vld got=%b exp=0", bus.mem_req_vld_o); else pass_cnt++;
    total_cnt++; if (bus.mem_resp_rdy_o !== 1'b0) $display("FAIL rst_mem_resp_rdy got=%b exp=0", bus.mem_resp_rdy_o); else pass_cnt++;
    total_cnt++; if (err_cnt !== 8'd0) $display("FAIL rst_err_cnt got=%0d exp=0", err_cnt); else pass_cnt++;
    total_cnt++; if (bus.ptw_walk_resp_pte_o !== 64'd0) $display("FAIL rst_pte got=%h exp=0", bus.ptw_walk_resp_pte_o); else pass_cnt++;
    rst = 1'b0;
    step();
    total_cnt++; if (bus.ptw_walk_req_rdy_o !== 1'b1) $display("FAIL rst_req_rdy got=%b exp=1", bus.ptw_walk_req_rdy_o); else pass_cnt++;
  endtask
  task automatic test_normal();
    bus.ptw_walk_req_vld_i = 1'b1; bus.ptw_walk_req_addr_i = 56'h1000; bus.ptw_walk_req_id_i = 1'b1;
    total_cnt++; if (bus.ptw_walk_req_rdy_o !== 1'b1) $display("FAIL norm_req_rdy got=%b exp=1", bus.ptw_walk_req_rdy_o); else pass_cnt++;
    step();
    bus.ptw_walk_req_vld_i = 1'b0;
    total_cnt++; if (bus.mem_req_vld_o !== 1'b1) $display("FAIL norm_mem_req_vld got=%b exp=1", bus.mem_req_vld_o); else pass_cnt++;
    total_cnt++; if (bus.mem_req_addr_o !== 56'h1000) $display("FAIL norm_mem_req_addr got=%h exp=1000", bus.mem_req_addr_o); else pass_cnt++;
    step();
    total_cnt++; if (bus.mem_req_vld_o !== 1'b0) $display("FAIL norm_mem_req_drop got=%b exp=0", bus.mem_req_vld_o); else pass_cnt++;
    total_cnt++; if (bus.mem_resp_rdy_o !== 1'b1) $display("FAIL norm_mem_resp_rdy got=%b exp=1", bus.mem_resp_rdy_o); else pass_cnt++;
    repeat (2) step();
    bus.mem_resp_vld_i = 1'b1; bus.mem_resp_data_i = 64'h2000_0001;
    step();
    bus.mem_resp_vld_i = 1'b0;
    total_cnt++; if (bus.ptw_walk_resp_vld_o !== 1'b1) $display("FAIL norm_resp_vld got=%b exp=1", bus.ptw_walk_resp_vld_o); else pass_cnt++;
    total_cnt++; if (bus.ptw_walk_resp_pte_o !== 64'h2000_0001) $display("FAIL norm_pte got=%h exp=20000001", bus.ptw_walk_resp_pte_o); else pass_cnt++;
    total_cnt++; if (bus.mem_resp_rdy_o !== 1'b0) $display("FAIL norm_mem_resp_rdy_resp got=%b exp=0", bus.mem_resp_rdy_o); else pass_cnt++;
    bus.ptw_walk_resp_rdy_i = 1'b1;
    step();
    bus.ptw_walk_resp_rdy_i = 1'b0;
    total_cnt++; if (bus.ptw_walk_resp_vld_o !== 1'b0) $display("FAIL norm_resp_done got=%b exp=0", bus.ptw_walk_resp_vld_o); else pass_cnt++;
    total_cnt++; if (bus.ptw_walk_req_rdy_o !== 1'b1) $display("FAIL norm_req_rdy_back got=%b exp=1", bus.ptw_walk_req_rdy_o); else pass_cnt++;
  endtask
  task automatic test_misaligned();
    bus.ptw_walk_req_vld_i = 1'b1; bus.ptw_walk_req_addr_i = 56'h1004;
    step();
    bus.ptw_walk_req_vld_i = 1'b0;
    total_cnt++; if (bus.mem_req_vld_o !== 1'b0) $display("FAIL mis_mem_req_vld got=%b exp=0", bus.mem_req_vld_o); else pass_cnt++;
    total_cnt++; if (bus.ptw_walk_resp_vld_o !== 1'b1) $display("FAIL mis_resp_vld got=%b exp=1", bus.ptw_walk_resp_vld_o); else pass_cnt++;
    total_cnt++; if (bus.ptw_walk_resp_pte_o !== 64'd0) $display("FAIL mis_pte got=%h exp=0", bus.ptw_walk_resp_pte_o); else pass_cnt++;
    total_cnt++; if (err_cnt !== 8'd1) $display("FAIL mis_err_cnt got=%0d exp=1", err_cnt); else pass_cnt++;
    bus.ptw_walk_resp_rdy_i = 1'b1;
    step();
    bus.ptw_walk_resp_rdy_i = 1'b0;
  endtask
  task automatic test_bus_error();
    bus.mem_req_rdy_i = 1'b0;
    bus.ptw_walk_req_vld_i = 1'b1; bus.ptw_walk_req_addr_i = 56'h2000;
    step();
    bus.ptw_walk_req_vld_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total_cnt++; if (bus.mem_req_vld_o !== 1'b1 || bus.mem_req_addr_o !== 56'h2000) $display("FAIL berr_mem_req_hold got=%b/%h exp=1/2000", bus.mem_req_vld_o, bus.mem_req_addr_o); else pass_cnt++;
      step();
    end
    bus.mem_req_rdy_i = 1'b1;
    step();
    bus.mem_resp_vld_i = 1'b1; bus.mem_resp_err_i = 1'b1; bus.mem_resp_data_i = 64'hFFFF;
    step();
    bus.mem_resp_vld_i = 1'b0; bus.mem_resp_err_i = 1'b0;
    total_cnt++; if (bus.ptw_walk_resp_vld_o !== 1'b1) $display("FAIL berr_resp_vld got=%b exp=1", bus.ptw_walk_resp_vld_o); else pass_cnt++;
    total_cnt++; if (bus.ptw_walk_resp_pte_o !== 64'd0) $display("FAIL berr_pte got=%h exp=0", bus.ptw_walk_resp_pte_o); else pass_cnt++;
    total_cnt++; if (err_cnt !== 8'd2) $display("FAIL berr_err_cnt got=%0d exp=2", err_cnt); else pass_cnt++;
    bus.ptw_walk_resp_rdy_i = 1'b1;
    step();
    bus.ptw_walk_resp_rdy_i = 1'b0;
  endtask
  task automatic test_discard();
    bus.mem_resp_vld_i = 1'b1; bus.mem_resp_data_i = 64'h99;
    total_cnt++; if (bus.mem_resp_rdy_o !== 1'b0) $display("FAIL disc_mem_resp_rdy got=%b exp=0", bus.mem_resp_rdy_o); else pass_cnt++;
    step();
    bus.mem_resp_vld_i = 1'b0;
    total_cnt++; if (bus.ptw_walk_resp_vld_o !== 1'b0 || bus.ptw_walk_req_rdy_o !== 1'b1) $display("FAIL disc_state got=%b/%b exp=0/1", bus.ptw_walk_resp_vld_o, bus.ptw_walk_req_rdy_o); else pass_cnt++;
    total_cnt++; if (err_cnt !== 8'd2) $display("FAIL disc_err_cnt got=%0d exp=2", err_cnt); else pass_cnt++;
  endtask
  task automatic test_back_to_back();
    bus.ptw_walk_req_vld_i = 1'b1; bus.ptw_walk_req_addr_i = 56'h3000;
    step();
    bus.ptw_walk_req_vld_i = 1'b0;
    step();
    bus.mem_resp_vld_i = 1'b1; bus.mem_resp_data_i = 64'h0123_4567_89AB_CDEF;
    step();
    bus.mem_resp_vld_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total_cnt++; if (bus.ptw_walk_resp_vld_o !== 1'b1 || bus.ptw_walk_resp_pte_o !== 64'h0123_4567_89AB_CDEF) $display("FAIL bp_hold cyc=%0d got=%b/%h exp=1/0123456789abcdef", i, bus.ptw_walk_resp_vld_o, bus.ptw_walk_resp_pte_o); else pass_cnt++;
      total_cnt++; if (bus.ptw_walk_req_rdy_o !== 1'b0) $display("FAIL bp_req_rdy cyc=%0d got=%b exp=0", i, bus.ptw_walk_req_rdy_o); else pass_cnt++;
      step();
    end
    bus.ptw_walk_resp_rdy_i = 1'b1;
    bus.ptw_walk_req_vld_i = 1'b1; bus.ptw_walk_req_addr_i = 56'h4000;
    total_cnt++; if (bus.ptw_walk_req_rdy_o !== 1'b0) $display("FAIL b2b_rdy_on_hs got=%b exp=0", bus.ptw_walk_req_rdy_o); else pass_cnt++;
    step();
    bus.ptw_walk_resp_rdy_i = 1'b0;
    total_cnt++; if (bus.ptw_walk_req_rdy_o !== 1'b1 || bus.mem_req_vld_o !== 1'b0) $display("FAIL b2b_after_hs got=%b/%b exp=1/0", bus.ptw_walk_req_rdy_o, bus.mem_req_vld_o); else pass_cnt++;
    step();
    bus.ptw_walk_req_vld_i = 1'b0;
    total_cnt++; if (bus.mem_req_vld_o !== 1'b1 || bus.mem_req_addr_o !== 56'h4000) $display("FAIL b2b_mem_req got=%b/%h exp=1/4000", bus.mem_req_vld_o, bus.mem_req_addr_o); else pass_cnt++;
    step();
    bus.mem_resp_vld_i = 1'b1; bus.mem_resp_data_i = 64'h55;
    step();
    bus.mem_resp_vld_i = 1'b0;
    total_cnt++; if (bus.ptw_walk_resp_pte_o !== 64'h55) $display("FAIL b2b_pte got=%h exp=55", bus.ptw_walk_resp_pte_o); else pass_cnt++;
    bus.ptw_walk_resp_rdy_i = 1'b1;
    step();
    bus.ptw_walk_resp_rdy_i = 1'b0;
  endtask
  task automatic test_reset_mid_walk();
    bus.ptw_walk_req_vld_i = 1'b1; bus.ptw_walk_req_addr_i = 56'h5000;
    step();
    bus.ptw_walk_req_vld_i = 1'b0;
    step();
    total_cnt++; if (bus.mem_resp_rdy_o !== 1'b1) $display("FAIL mrst_in_wait got=%b exp=1", bus.mem_resp_rdy_o); else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total_cnt++; if (bus.mem_resp_rdy_o !== 1'b0 || bus.mem_req_vld_o !== 1'b0 || bus.ptw_walk_resp_vld_o !== 1'b0) $display("FAIL mrst_valids got=%b%b%b exp=000", bus.mem_resp_rdy_o, bus.mem_req_vld_o, bus.ptw_walk_resp_vld_o); else pass_cnt++;
    total_cnt++; if (err_cnt !== 8'd0) $display("FAIL mrst_err_cnt got=%0d exp=0", err_cnt); else pass_cnt++;
    total_cnt++; if (bus.ptw_walk_resp_pte_o !== 64'd0) $display("FAIL mrst_pte got=%h exp=0", bus.ptw_walk_resp_pte_o); else pass_cnt++;
    step();
    rst = 1'b0;
    bus.mem_resp_vld_i = 1'b1; bus.mem_resp_data_i = 64'hDEAD;
    step();
    bus.mem_resp_vld_i = 1'b0;
    total_cnt++; if (bus.ptw_walk_resp_vld_o !== 1'b0 || bus.ptw_walk_req_rdy_o !== 1'b1) $display("FAIL mrst_late_ignored got=%b/%b exp=0/1", bus.ptw_walk_resp_vld_o, bus.ptw_walk_req_rdy_o); else pass_cnt++;
    bus.ptw_walk_req_vld_i = 1'b1; bus.ptw_walk_req_addr_i = 56'h6000;
    step();
    bus.ptw_walk_req_vld_i = 1'b0;
    total_cnt++; if (bus.mem_req_addr_o !== 56'h6000) $display("FAIL mrst_next_addr got=%h exp=6000", bus.mem_req_addr_o); else pass_cnt++;
    step();
    bus.mem_resp_vld_i = 1'b1; bus.mem_resp_data_i = 64'h77;
    step();
    bus.mem_resp_vld_i = 1'b0;
    total_cnt++; if (bus.ptw_walk_resp_vld_o !== 1'b1 || bus.ptw_walk_resp_pte_o !== 64'h77) $display("FAIL mrst_next_resp got=%b/%h exp=1/77", bus.ptw_walk_resp_vld_o, bus.ptw_walk_resp_pte_o); else pass_cnt++;
    bus.ptw_walk_resp_rdy_i = 1'b1;
    step();
    bus.ptw_walk_resp_rdy_i = 1'b0;
  endtask
`ifdef RVH_PTW_MEM_TIMEOUT_EN
  task automatic test_timeout();
    bus.ptw_walk_req_vld_i = 1'b1; bus.ptw_walk_req_addr_i = 56'h7000;
    step();
    bus.ptw_walk_req_vld_i = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      total_cnt++; if (bus.ptw_walk_resp_vld_o !== 1'b0) $display("FAIL tmo_early cyc=%0d got=%b exp=0", i, bus.ptw_walk_resp_vld_o); else pass_cnt++;
      step();
    end
    total_cnt++; if (bus.ptw_walk_resp_vld_o !== 1'b1 || bus.ptw_walk_resp_pte_o !== 64'd0) $display("FAIL tmo_resp got=%b/%h exp=1/0", bus.ptw_walk_resp_vld_o, bus.ptw_walk_resp_pte_o); else pass_cnt++;
    total_cnt++; if (err_cnt !== 8'd1) $display("FAIL tmo_err_cnt got=%0d exp=1", err_cnt); else pass_cnt++;
    bus.ptw_walk_resp_rdy_i = 1'b1;
    step();
    bus.ptw_walk_resp_rdy_i = 1'b0;
    total_cnt++; if (bus.ptw_walk_req_rdy_o !== 1'b0 || bus.mem_resp_rdy_o !== 1'b1) $display("FAIL tmo_drop got=%b/%b exp=0/1", bus.ptw_walk_req_rdy_o, bus.mem_resp_rdy_o); else pass_cnt++;
    bus.ptw_walk_req_vld_i = 1'b1; bus.ptw_walk_req_addr_i = 56'h8000;
    step();
    bus.ptw_walk_req_vld_i = 1'b0;
    total_cnt++; if (bus.mem_req_vld_o !== 1'b0 || bus.ptw_walk_req_rdy_o !== 1'b0) $display("FAIL tmo_blocked got=%b/%b exp=0/0", bus.mem_req_vld_o, bus.ptw_walk_req_rdy_o); else pass_cnt++;
    bus.mem_resp_vld_i = 1'b1; bus.mem_resp_data_i = 64'hABC;
    step();
    bus.mem_resp_vld_i = 1'b0;
    total_cnt++; if (bus.ptw_walk_req_rdy_o !== 1'b1 || bus.mem_resp_rdy_o !== 1'b0 || bus.ptw_walk_resp_vld_o !== 1'b0) $display("FAIL tmo_drained got=%b%b%b exp=100", bus.ptw_walk_req_rdy_o, bus.mem_resp_rdy_o, bus.ptw_walk_resp_vld_o); else pass_cnt++;
    total_cnt++; if (bus.ptw_walk_resp_pte_o !== 64'd0) $display("FAIL tmo_data_discarded got=%h exp=0", bus.ptw_walk_resp_pte_o); else pass_cnt++;
  endtask
`endif
  task automatic test_saturation();
    bus.ptw_walk_resp_rdy_i = 1'b1;
    bus.ptw_walk_req_addr_i = 56'h9001;
    for (int i = 0; i < 260; i++) begin
      bus.ptw_walk_req_vld_i = 1'b1;
      step();
      bus.ptw_walk_req_vld_i = 1'b0;
      step();
    end
    bus.ptw_walk_resp_rdy_i = 1'b0;
    total_cnt++; if (err_cnt !== 8'd255) $display("FAIL sat_err_cnt got=%0d exp=255", err_cnt); else pass_cnt++;
    total_cnt++; if (bus.ptw_walk_req_rdy_o !== 1'b1 || bus.ptw_walk_resp_vld_o !== 1'b0) $display("FAIL sat_idle got=%b/%b exp=1/0", bus.ptw_walk_req_rdy_o, bus.ptw_walk_resp_vld_o); else pass_cnt++;
  endtask
  initial begin
    rst = 1'b1;
    bus.ptw_walk_req_vld_i = 1'b0; bus.ptw_walk_req_id_i = 1'b0; bus.ptw_walk_req_addr_i = '0;
    bus.ptw_walk_resp_rdy_i = 1'b0; bus.mem_req_rdy_i = 1'b1;
    bus.mem_resp_vld_i = 1'b0; bus.mem_resp_data_i = '0; bus.mem_resp_err_i = 1'b0;
    test_reset();
    test_normal();
    test_misaligned();
    test_bus_error();
    test_discard();
    test_back_to_back();
    test_reset_mid_walk();
`ifdef RVH_PTW_MEM_TIMEOUT_EN
    test_timeout();
`endif
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
